// File: rtl/fifo_burst_framer_pkg.sv
// Shared definitions for the FIFO burst framer: state encoding, header sync nibble
// and the pointer-difference fill level.
package fifo_burst_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LENGTH,
    ST_PAYLOAD,
    ST_CHECKSUM
  } state_t;

  localparam logic [3:0] SYNC_NIBBLE = 4'hA;

  // Modular subtraction so a wrapped write pointer still yields the true fill.
  function automatic logic [31:0] fill_level(input logic [31:0] wr_ptr,
                                             input logic [31:0] rd_ptr,
                                             input int          addr_w);
    logic [31:0] mask;
    mask = (32'd1 << addr_w) - 32'd1;
    return (wr_ptr - rd_ptr) & mask;
  endfunction

endpackage

// File: rtl/fifo_burst_framer_skid.sv
// Two-entry byte FIFO that catches FIFO read data one cycle after the strobe and
// holds it until the output stream accepts it.
module byte_skid_buf (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [1:0] count
);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count_q;
  logic       push;
  logic       pop;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign count     = count_q;
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (count_q != 2'd2 || pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  // NOTE: the storage array has no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/fifo_burst_framer.sv
// Drains the tracking FIFO in bursts and wraps each burst as a framed byte packet:
// header, length, payload, checksum on a valid/ready byte stream.
module fifo_burst_framer
  import fifo_burst_framer_pkg::*;
#(
  parameter logic [3:0] CHAN_ID   = 4'h0,
  parameter int         MAX_BURST = 64,
  parameter int         ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fifo_addr_in,
  input  logic [ADDR_W-1:0] fifo_addr_out,
  input  logic [7:0]        fifo_data,
  output logic              fifo_read,
  input  logic              flush,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy
);

  localparam logic [31:0] MAX_BURST_U = 32'(MAX_BURST);
  localparam logic [7:0]  LEN_MAX     = 8'(MAX_BURST);

  state_t            state_q, state_d;
  logic [7:0]        len_q;
  logic [7:0]        rd_cnt_q;
  logic [7:0]        sent_q;
  logic [7:0]        csum_q;
  logic              rd_pending_q;
  logic [ADDR_W-1:0] fill;
  logic              start;
  logic [7:0]        start_len;
  logic              skid_valid;
  logic [7:0]        skid_data;
  logic [1:0]        skid_count;
  logic              skid_pop;
  logic [2:0]        slots_used;

  assign fill      = ADDR_W'(fill_level(32'(fifo_addr_in), 32'(fifo_addr_out), ADDR_W));
  assign start     = (32'(fill) >= MAX_BURST_U) || (flush && fill != '0);
  assign start_len = (32'(fill) >= MAX_BURST_U) ? LEN_MAX : 8'(fill);

  assign skid_pop   = (state_q == ST_PAYLOAD) && skid_valid && m_ready;
  // Occupancy counts the byte leaving this cycle as already gone, which keeps the
  // read strobe continuous while m_ready is held high.
  assign slots_used = 3'(skid_count) + 3'(rd_pending_q) - 3'(skid_pop);
  assign fifo_read  = (state_q == ST_PAYLOAD) && (rd_cnt_q != len_q) &&
                      (fill != '0) && (slots_used < 3'd2);
  assign busy       = (state_q != ST_IDLE);

  byte_skid_buf u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_pending_q),
    .in_data   (fifo_data),
    .out_ready ((state_q == ST_PAYLOAD) && m_ready),
    .out_valid (skid_valid),
    .out_data  (skid_data),
    .count     (skid_count)
  );

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_HEADER;
      end
      ST_HEADER: begin
        m_valid = 1'b1;
        m_data  = {SYNC_NIBBLE, CHAN_ID};
        if (m_ready) state_d = ST_LENGTH;
      end
      ST_LENGTH: begin
        m_valid = 1'b1;
        m_data  = len_q;
        if (m_ready) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        m_valid = skid_valid;
        m_data  = skid_data;
        if (skid_pop && sent_q == len_q - 8'd1) state_d = ST_CHECKSUM;
      end
      ST_CHECKSUM: begin
        m_valid = 1'b1;
        m_data  = 8'(~csum_q + 8'd1);
        m_last  = 1'b1;
        if (m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_q        <= 8'd0;
      rd_cnt_q     <= 8'd0;
      sent_q       <= 8'd0;
      csum_q       <= 8'd0;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= fifo_read;
      if (state_q == ST_IDLE && start) begin
        len_q    <= start_len;
        rd_cnt_q <= 8'd0;
        sent_q   <= 8'd0;
        csum_q   <= 8'd0;
      end
      if (fifo_read) rd_cnt_q <= rd_cnt_q + 8'd1;
      if (state_q == ST_LENGTH && m_ready) csum_q <= csum_q + len_q;
      if (skid_pop) begin
        csum_q <= csum_q + skid_data;
        sent_q <= sent_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_framer.sv
// Scoreboard bench for fifo_burst_framer: a behavioural FIFO feeds the DUT, stimulus
// queues expected frames, and a negedge monitor compares every accepted byte.
module tb_fifo_burst_framer;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, ptr_init;
  logic [7:0]        mem [2**ADDR_W];
  logic [7:0]        fifo_data;
  logic              fifo_read;
  logic              flush;
  logic [7:0]        m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic              wr_en;
  logic [7:0]        wr_byte;
  logic              rand_ready;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    beat_cnt = 0;

  always #5 clk = ~clk;

  fifo_burst_framer #(.CHAN_ID(4'h0), .MAX_BURST(64), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .fifo_addr_in  (wr_ptr),
    .fifo_addr_out (rd_ptr),
    .fifo_data     (fifo_data),
    .fifo_read     (fifo_read),
    .flush         (flush),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .busy          (busy)
  );

  // Behavioural tracking FIFO: pointers reset to ptr_init, data appears after read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= ptr_init;
      rd_ptr    <= ptr_init;
      fifo_data <= 8'h00;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_byte;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (fifo_read) begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pay(input int i, input logic [7:0] first, input logic [7:0] step);
    return 8'(int'(first) + i * int'(step));
  endfunction

  function automatic logic [7:0] frame_csum(input int len, input logic [7:0] first,
                                            input logic [7:0] step);
    logic [7:0] sum;
    sum = 8'(len);
    for (int i = 0; i < len; i++) sum = sum + pay(i, first, step);
    return 8'(8'd0 - sum);
  endfunction

  task automatic expect_frame(input int len, input logic [7:0] first, input logic [7:0] step,
                              input logic [7:0] csum);
    exp_q.push_back('{data: 8'hA0, last: 1'b0});
    exp_q.push_back('{data: 8'(len), last: 1'b0});
    for (int i = 0; i < len; i++) exp_q.push_back('{data: pay(i, first, step), last: 1'b0});
    exp_q.push_back('{data: csum, last: 1'b1});
  endtask

  task automatic write_bytes(input int n, input logic [7:0] first, input logic [7:0] step);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_byte = pay(i, first, step);
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_busy"}, busy, 0);
  endtask

  // Monitor: compares accepted bytes, stall stability, frame sums and busy release.
  logic [7:0] fsum;
  logic [7:0] hold_data;
  int         idx;
  logic       stalled;
  logic       after_last;
  beat_t      e;

  always @(negedge clk) begin
    if (!rst_n) begin
      idx = 0; fsum = 8'h00; stalled = 1'b0; after_last = 1'b0;
    end else begin
      if (after_last) begin
        check("busy_after_last", busy, 0);
        after_last = 1'b0;
      end
      if (stalled) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, hold_data);
      end
      if (m_valid && m_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got 0x%0h with no byte expected at %0t", m_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_data, e.data);
          check("beat_last", m_last, e.last);
        end
        if (idx > 0) fsum = fsum + m_data;
        if (m_last) begin
          check("frame_sum_zero", fsum, 0);
          idx = 0; fsum = 8'h00; after_last = 1'b1;
        end else begin
          idx++;
        end
      end
      stalled   = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  initial begin
    int b0;
    int c;
    rst_n = 1'b0; ptr_init = '0; wr_en = 1'b0; wr_byte = 8'h00;
    flush = 1'b0; rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full 64-byte burst, always ready.
    expect_frame(64, 8'h00, 8'h01, 8'hE0);
    b0 = beat_cnt;
    write_bytes(64, 8'h00, 8'h01);
    wait_drain(400, "t1");
    check("t1_beats", beat_cnt - b0, 67);

    // Short burst waits for flush.
    write_bytes(5, 8'h01, 8'h01);
    repeat (20) @(posedge clk);
    #1;
    check("t2_idle_busy", busy, 0);
    check("t2_idle_valid", m_valid, 0);
    expect_frame(5, 8'h01, 8'h01, 8'hEC);
    flush = 1'b1;
    wait_drain(100, "t2");
    flush = 1'b0;

    // Same frame as the first, with a random ready pattern.
    rand_ready = 1'b1;
    expect_frame(64, 8'h00, 8'h01, 8'hE0);
    write_bytes(64, 8'h00, 8'h01);
    wait_drain(1000, "t4");
    rand_ready = 1'b0;

    // 130 bytes split as 64 + 64 + 2.
    expect_frame(64, 8'h10, 8'h01, frame_csum(64, 8'h10, 8'h01));
    expect_frame(64, 8'h50, 8'h01, frame_csum(64, 8'h50, 8'h01));
    expect_frame(2, 8'h90, 8'h01, frame_csum(2, 8'h90, 8'h01));
    write_bytes(130, 8'h10, 8'h01);
    flush = 1'b1;
    wait_drain(1000, "t5");
    flush = 1'b0;

    // Reset in the middle of the payload.
    expect_frame(64, 8'h00, 8'h01, 8'hE0);
    b0 = beat_cnt;
    write_bytes(64, 8'h00, 8'h01);
    c = 0;
    while (beat_cnt - b0 < 10 && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("t6_reached_payload", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_fifo_read", fifo_read, 0);
    check("t6_async_m_valid", m_valid, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_m_last", m_last, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t6_idle_busy", busy, 0);
    check("t6_idle_valid", m_valid, 0);
    check("t6_idle_read", fifo_read, 0);

    // Pointers start near the top so the write pointer wraps.
    ptr_init = 11'd2046;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_frame(64, 8'hC0, 8'h03, frame_csum(64, 8'hC0, 8'h03));
    write_bytes(64, 8'hC0, 8'h03);
    wait_drain(400, "t3");
    check("t3_rd_ptr_wrapped", 32'(rd_ptr), 62);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
